// File: rtl/sar_adc_scan.sv
// SAR conversion sequencer for the comparator/DAC1 path.
// Round-robin scans the enabled comparator inputs. For each channel it selects
// the input, lets it settle with AD_RST high, and then runs a binary search on
// DAC1 using the synchronised comparator output. One result is posted per
// channel.
module sar_adc_scan #(
    parameter int NCH        = 18,
    parameter int DW         = 10,
    parameter int CH_SETTLE  = 8,
    parameter int BIT_SETTLE = 4
) (
    input  logic           clk,
    input  logic           rstz,
    input  logic           scan_en,
    input  logic [NCH-1:0] ch_mask,
    input  logic           cmp_o,
    output logic [DW-1:0]  dac1,
    output logic           dac1_en,
    output logic           ad_rst,
    output logic           ad_hold,
    output logic [NCH-1:0] cmp_sel,
    output logic [DW-1:0]  res_dat,
    output logic [4:0]     res_ch,
    output logic           res_vld,
    output logic           scan_done
);

    localparam int CHW   = 5;
    localparam int CNT_W = $clog2((CH_SETTLE > BIT_SETTLE ? CH_SETTLE : BIT_SETTLE) + 1);
    localparam int BW    = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [DW-1:0] MSB = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SEL, CONV, STORE} state_t;

    state_t           state;
    logic [CHW-1:0]   ch;
    logic [CNT_W-1:0] cnt;
    logic [BW-1:0]    bidx;
    logic             cmp_m, cmp_s;

    logic [CHW-1:0]   lo_ch, up_ch, hi_ch, nxt_ch;
    logic             up_hit, hi_hit;

    function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] c);
        logic [NCH-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // COMP_O is asynchronous to clk; only the second flop feeds decisions
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            cmp_m <= 1'b0;
            cmp_s <= 1'b0;
        end else begin
            cmp_m <= cmp_o;
            cmp_s <= cmp_m;
        end
    end

    // Mask search: lowest set bit, lowest set bit above ch, highest set bit
    always_comb begin
        lo_ch  = '0;
        up_ch  = '0;
        up_hit = 1'b0;
        hi_ch  = '0;
        hi_hit = 1'b0;
        // descending so the last hit is the lowest qualifying bit
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                lo_ch = CHW'(i);
                if (CHW'(i) > ch) begin
                    up_ch  = CHW'(i);
                    up_hit = 1'b1;
                end
            end
        end
        // ascending so the last hit is the highest set bit
        for (int i = 0; i < NCH; i++) begin
            if (ch_mask[i]) begin
                hi_ch  = CHW'(i);
                hi_hit = 1'b1;
            end
        end
        nxt_ch = up_hit ? up_ch : lo_ch;
    end

    // Sequencer FSM; every analog drive and result output is registered here
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state     <= IDLE;
            ch        <= '0;
            cnt       <= '0;
            bidx      <= '0;
            dac1      <= '0;
            dac1_en   <= 1'b0;
            ad_rst    <= 1'b0;
            ad_hold   <= 1'b0;
            cmp_sel   <= '0;
            res_dat   <= '0;
            res_ch    <= '0;
            res_vld   <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            res_vld   <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    dac1    <= '0;
                    dac1_en <= 1'b0;
                    ad_rst  <= 1'b0;
                    ad_hold <= 1'b0;
                    cmp_sel <= '0;
                    cnt     <= '0;
                    if (scan_en && |ch_mask) begin
                        state   <= SEL;
                        ch      <= lo_ch;
                        cmp_sel <= onehot(lo_ch);
                        dac1_en <= 1'b1;
                        ad_rst  <= 1'b1;
                    end
                end
                SEL: begin
                    if (!scan_en) begin
                        state   <= IDLE;
                        dac1    <= '0;
                        dac1_en <= 1'b0;
                        ad_rst  <= 1'b0;
                        ad_hold <= 1'b0;
                        cmp_sel <= '0;
                        cnt     <= '0;
                    end else if (cnt == CNT_W'(CH_SETTLE - 1)) begin
                        state   <= CONV;
                        cnt     <= '0;
                        bidx    <= BW'(DW - 1);
                        dac1    <= MSB;
                        ad_rst  <= 1'b0;
                        ad_hold <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CONV: begin
                    if (!scan_en) begin
                        state   <= IDLE;
                        dac1    <= '0;
                        dac1_en <= 1'b0;
                        ad_rst  <= 1'b0;
                        ad_hold <= 1'b0;
                        cmp_sel <= '0;
                        cnt     <= '0;
                    end else if (cnt == CNT_W'(BIT_SETTLE - 1)) begin
                        cnt        <= '0;
                        dac1[bidx] <= cmp_s;
                        if (bidx == '0) begin
                            state   <= STORE;
                            ad_hold <= 1'b0;
                            cmp_sel <= '0;
                        end else begin
                            dac1[bidx - 1'b1] <= 1'b1;
                            bidx              <= bidx - 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STORE: begin
                    res_dat   <= dac1;
                    res_ch    <= ch;
                    res_vld   <= 1'b1;
                    scan_done <= hi_hit && (hi_ch == ch);
                    cnt       <= '0;
                    dac1      <= '0;
                    if (scan_en && |ch_mask) begin
                        state   <= SEL;
                        ch      <= nxt_ch;
                        cmp_sel <= onehot(nxt_ch);
                        dac1_en <= 1'b1;
                        ad_rst  <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        dac1_en <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_scan.sv
// Self-checking bench for sar_adc_scan. An analog-side model drives COMP_O
// from per-channel input levels. Expected results come from the channel order
// implied by the mask and from the input level itself.
module tb_sar_adc_scan;

    localparam int NCH = 18;
    localparam int DW  = 10;

    logic           clk = 1'b0;
    logic           rstz = 1'b0;
    logic           scan_en = 1'b0;
    logic [NCH-1:0] ch_mask = '0;
    logic           cmp_o;
    logic [DW-1:0]  dac1;
    logic           dac1_en, ad_rst, ad_hold;
    logic [NCH-1:0] cmp_sel;
    logic [DW-1:0]  res_dat;
    logic [4:0]     res_ch;
    logic           res_vld, scan_done;

    int             checks = 0;
    int             errors = 0;
    logic [DW-1:0]  vin [NCH];
    bit             multi_hot = 1'b0;
    int             order[$];

    sar_adc_scan #(.NCH(NCH), .DW(DW), .CH_SETTLE(8), .BIT_SETTLE(4)) dut (
        .clk(clk), .rstz(rstz), .scan_en(scan_en), .ch_mask(ch_mask),
        .cmp_o(cmp_o), .dac1(dac1), .dac1_en(dac1_en), .ad_rst(ad_rst),
        .ad_hold(ad_hold), .cmp_sel(cmp_sel), .res_dat(res_dat),
        .res_ch(res_ch), .res_vld(res_vld), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // Each input sits half an LSB above its code, so the SAR should land on vin
    always_comb begin
        cmp_o = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (cmp_sel[i] && (vin[i] >= dac1)) cmp_o = 1'b1;
    end

    // Sticky flag if the input select ever shows more than one bit
    always @(negedge clk) if (!$onehot0(cmp_sel)) multi_hot <= 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic build_order(input logic [NCH-1:0] m);
        order.delete();
        for (int i = 0; i < NCH; i++) if (m[i]) order.push_back(i);
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (res_vld) begin
                ok = 1'b1;
                return;
            end
        end
        check("res_vld_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_hold(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ad_hold) begin
                ok = 1'b1;
                return;
            end
        end
        check("ad_hold_timeout", 64'd0, 64'd1);
    endtask

    // Expect n results following the mask's round-robin order from its lowest channel
    task automatic expect_seq(input int n);
        bit ok;
        int e;
        for (int k = 0; k < n; k++) begin
            wait_res(ok);
            if (!ok) return;
            e = order[k % order.size()];
            check("res_ch", 64'(res_ch), 64'(e));
            check("res_dat", 64'(res_dat), 64'(vin[e]));
            check("scan_done", 64'(scan_done), 64'(e == order[order.size() - 1]));
        end
    endtask

    task automatic stop_scan();
        scan_en = 1'b0;
        tick(3);
        check("idle_drive", 64'({dac1, dac1_en, ad_rst, ad_hold, cmp_sel}), 64'd0);
    endtask

    task automatic check_no_res(input string tag, input int cycles);
        int cnt;
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (res_vld) cnt++;
        end
        check(tag, 64'(cnt), 64'd0);
    endtask

    initial begin
        bit ok;
        int lat;
        logic [DW-1:0] prev;
        logic [NCH-1:0] m;

        for (int i = 0; i < NCH; i++) vin[i] = '0;

        // reset state
        #1;
        check("rst_drive", 64'({dac1, dac1_en, ad_rst, ad_hold, cmp_sel}), 64'd0);
        check("rst_res", 64'({res_dat, res_ch, res_vld, scan_done}), 64'd0);
        @(negedge clk);
        rstz = 1'b1;
        tick(2);

        // single channel, fixed level, latency from SEL entry
        vin[0]  = 10'h2A5;
        ch_mask = 18'h00001;
        scan_en = 1'b1;
        @(negedge clk);
        check("sel_entry", 64'({ad_rst, dac1_en, cmp_sel}), 64'({1'b1, 1'b1, 18'h00001}));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_vld && lat < 200);
        check("latency", 64'(lat), 64'd49);
        check("t1_res_dat", 64'(res_dat), 64'h2A5);
        check("t1_res_ch", 64'(res_ch), 64'd0);
        check("t1_scan_done", 64'(scan_done), 64'd1);
        stop_scan();

        // three channel round robin
        for (int i = 0; i < NCH; i++) vin[i] = DW'($urandom_range(0, 1023));
        ch_mask = 18'h20005;
        build_order(ch_mask);
        scan_en = 1'b1;
        expect_seq(6);
        stop_scan();

        // boundary codes
        vin[3]  = 10'h3FF;
        vin[9]  = 10'h000;
        ch_mask = 18'h00208;
        build_order(ch_mask);
        scan_en = 1'b1;
        expect_seq(4);
        stop_scan();

        // random masks and levels
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < NCH; i++) vin[i] = DW'($urandom_range(0, 1023));
            m = NCH'($urandom_range(1, (1 << NCH) - 1));
            ch_mask = m;
            build_order(m);
            scan_en = 1'b1;
            expect_seq((2 * order.size() + 1 > 12) ? 12 : 2 * order.size() + 1);
            stop_scan();
        end

        // abort during bit 5 trial
        vin[0]  = DW'($urandom_range(0, 1023));
        ch_mask = 18'h00001;
        prev    = res_dat;
        scan_en = 1'b1;
        wait_hold(ok);
        tick(17);
        check("bit5_trial", 64'(dac1), 64'({vin[0][9:6], 1'b1, 5'b0}));
        scan_en = 1'b0;
        @(negedge clk);
        check("abort_drive", 64'({dac1, dac1_en, ad_rst, ad_hold, cmp_sel}), 64'd0);
        check("abort_res_dat", 64'(res_dat), 64'(prev));
        check_no_res("abort_no_res", 100);

        // mask change during ch0 conversion
        vin[0]  = DW'($urandom_range(0, 1023));
        vin[2]  = DW'($urandom_range(0, 1023));
        ch_mask = 18'h00003;
        scan_en = 1'b1;
        wait_hold(ok);
        ch_mask = 18'h00004;
        wait_res(ok);
        check("mchg_ch0", 64'({res_ch, res_dat, scan_done}), 64'({5'd0, vin[0], 1'b0}));
        wait_res(ok);
        check("mchg_ch2", 64'({res_ch, res_dat, scan_done}), 64'({5'd2, vin[2], 1'b1}));
        wait_res(ok);
        check("mchg_ch2b", 64'({res_ch, res_dat, scan_done}), 64'({5'd2, vin[2], 1'b1}));
        stop_scan();

        // mask cleared while running: finish current channel, then idle
        vin[5]  = DW'($urandom_range(0, 1023));
        ch_mask = 18'h00020;
        scan_en = 1'b1;
        wait_hold(ok);
        ch_mask = '0;
        wait_res(ok);
        check("mzero_res", 64'({res_ch, res_dat, scan_done}), 64'({5'd5, vin[5], 1'b0}));
        tick(1);
        check("mzero_idle", 64'({dac1, dac1_en, ad_rst, ad_hold, cmp_sel}), 64'd0);
        check_no_res("mzero_no_res", 100);
        scan_en = 1'b0;
        tick(2);

        // async reset mid conversion, then restart from lowest channel
        vin[1]  = DW'($urandom_range(0, 1023));
        vin[2]  = DW'($urandom_range(0, 1023));
        ch_mask = 18'h00006;
        build_order(ch_mask);
        scan_en = 1'b1;
        wait_res(ok);
        check("prerst_ch", 64'(res_ch), 64'd1);
        wait_hold(ok);
        tick(5);
        #2 rstz = 1'b0;
        #1;
        check("arst_drive", 64'({dac1, dac1_en, ad_rst, ad_hold, cmp_sel}), 64'd0);
        check("arst_res", 64'({res_dat, res_ch, res_vld, scan_done}), 64'd0);
        @(negedge clk);
        rstz = 1'b1;
        expect_seq(2);
        stop_scan();

        check("onehot_sel", 64'(multi_hot), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
